arf_write_scheduler: RTL and testbench
======================================

# arf_write_scheduler

Write-port scheduler and initialiser for the 4-read/2-write architectural register file RAM. After reset, or on a clear request, it zeroes every entry two per cycle. It then maps two in-order commit writes and one low-priority debug write onto the RAM's two write ports. All RAM-facing outputs are registered, so the RAM sees clean, glitch-free write strobes. Two ordering rules hold: RAM port 2 wins on a same-address collision, and same-cycle ordering is preserved.

## Interface
- ADDR_WIDTH, 5, RAM address width (register selector)
- DATA_WIDTH, 32, RAM data width
- DATA_DEPTH, 32, RAM entries; must be even and ≤ 2^ADDR_WIDTH
- INIT_VAL, 0, value written to every entry during initialisation
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clr_req  in  1  single-cycle request to re-initialise the whole RAM
- init_done  out  1  high while in RUN
- com1_valid, com2_valid  in  1  commit write requests; com1 is older
- com1_addr, com2_addr  in  ADDR_WIDTH  commit destinations
- com1_data, com2_data  in  DATA_WIDTH  commit data
- com_ready  out  1  both commit slots accepted this cycle
- dbg_valid  in  1  debug write request; holds addr/data until accepted
- dbg_addr  in  ADDR_WIDTH  debug destination
- dbg_data  in  DATA_WIDTH  debug data
- dbg_ready  out  1  debug write accepted this cycle
- we1, we2  out  1  RAM write enables (registered)
- waddr1, waddr2  out  ADDR_WIDTH  RAM write addresses (registered)
- wdata1, wdata2  out  DATA_WIDTH  RAM write data (registered)

## Operation
- States: INIT and RUN. Reset forces INIT with init counter cnt = 0.
- INIT behaviour:
  - Each edge registers we1 = we2 = 1, waddr1 = cnt, waddr2 = cnt+1, wdata1 = wdata2 = INIT_VAL, then cnt += 2.
  - After the edge that issues entries DATA_DEPTH-2 and DATA_DEPTH-1, the next edge enters RUN.
  - com_ready = dbg_ready = 0. clr_req is ignored.
- RUN, combinational handshake:
  - com_ready = ~clr_req.
  - dbg_ready = ~clr_req & dbg_valid & ~(com1_valid & com2_valid), and additionally requires that dbg_addr matches no valid commit address.
- RUN, registered port mapping:
  - com1 accepted → port 1. com2 accepted → port 2.
  - Debug, when accepted, takes port 1 if com1_valid = 0, else port 2.
  - A port with nothing accepted registers we = 0. Its addr/data hold their previous values.
- Same-address collision: com1 and com2 to the same address issue both writes in the same edge. Port 2 (com2, younger) is the final RAM value.
- clr_req in RUN: the same edge enters INIT with cnt = 0 and we1 = we2 = 0. The first clear writes are issued on the following edge.
- Commits are never reordered, dropped or merged. Debug writes never overtake a same-address commit in the same cycle.

## Timing
- Reset values: state = INIT, cnt = 0, init_done = 0, we1 = we2 = 0, waddr1 = waddr2 = 0, wdata1 = wdata2 = 0.
- Reset is asynchronous. Assertion mid-INIT or mid-RUN immediately clears the outputs and restarts at cnt = 0.
- Initialisation, counting edges after reset deassert:
  - Edge k (k = 1..DATA_DEPTH/2) registers a write to entries 2k-2 and 2k-1.
  - Edge DATA_DEPTH/2+1 commits the last pair into the RAM and sets init_done = 1.
  - With defaults, init_done rises on edge 17.
- Write latency: a request accepted at edge n appears on we/waddr/wdata after edge n. The RAM stores it at edge n+1. Asynchronous RAM reads show the new value after edge n+1.
- Producers needing the value earlier must forward from their own pipeline; this block provides no bypass.
- clr_req accepted at edge n:
  - Edge n: init_done falls, we = 0.
  - Edge n+1: first clear pair (0, 1) is registered.
  - Edge n+1+DATA_DEPTH/2: init_done rises again.

## Test plan
- Reset release, no requests → edges 1..16 issue pairs (0,1)…(30,31) with data 0; init_done rises at edge 17; all 32 entries read 0.
- RUN: com1 = (3, 0xAAAA0001), com2 = (7, 0xBBBB0002) → same edge we1 = we2 = 1; next edge the RAM reads 3 → 0xAAAA0001 and 7 → 0xBBBB0002.
- com1 = (5, 0x11), com2 = (5, 0x22) → both enables set; entry 5 reads 0x22.
- dbg_valid held with (9, 0xD0): with both commits valid, dbg_ready = 0. Then com1 only (9, 0x1): dbg_ready = 0 (address match). Then com1 only (4, 0x2): dbg_ready = 1, debug lands on port 2, entry 9 = 0xD0.
- Write entry 12 = 0x55, then pulse clr_req → com_ready low that cycle; init_done low for 17 edges; entry 12 reads 0 afterwards; commits during INIT see com_ready = 0.
- Assert reset at edge 8 of INIT, release → outputs clear asynchronously; the sequence restarts at pair (0,1); init_done rises 17 edges after release.

Source files
------------

// File: rtl/arf_write_scheduler.sv
// rtl/arf_write_scheduler.sv - write-port scheduler and initialiser for the 4R/2W architectural register file
//
// Zeroes the whole RAM two entries per cycle after reset or a clear request,
// then maps two in-order commit writes and one low-priority debug write onto
// the RAM's two write ports. Every RAM-facing output is a flop.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   clr_req                     single-cycle request to re-initialise the RAM (RUN only)
//   init_done                   high while in RUN
//   com1_*/com2_*               commit write requests, com1 older than com2
//   com_ready                   both commit slots accepted this cycle
//   dbg_valid/addr/data         debug write request, held until dbg_ready
//   dbg_ready                   debug write accepted this cycle
//   we1/waddr1/wdata1           RAM write port 1 (registered)
//   we2/waddr2/wdata2           RAM write port 2 (registered, wins on same-address collision)

module arf_write_scheduler #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DATA_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    output logic                  init_done,

    input  logic                  com1_valid,
    input  logic [ADDR_WIDTH-1:0] com1_addr,
    input  logic [DATA_WIDTH-1:0] com1_data,
    input  logic                  com2_valid,
    input  logic [ADDR_WIDTH-1:0] com2_addr,
    input  logic [DATA_WIDTH-1:0] com2_data,
    output logic                  com_ready,

    input  logic                  dbg_valid,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_ready,

    output logic                  we1,
    output logic [ADDR_WIDTH-1:0] waddr1,
    output logic [DATA_WIDTH-1:0] wdata1,
    output logic                  we2,
    output logic [ADDR_WIDTH-1:0] waddr2,
    output logic [DATA_WIDTH-1:0] wdata2
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One extra bit so the counter can reach DATA_DEPTH even when the RAM
    // fills the full address space.
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_STEP = (ADDR_WIDTH + 1)'(2);

    state_t                state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] cnt_lo;

    logic run;
    logic dbg_hit;
    logic dbg_acc;
    logic dbg_p1;
    logic dbg_p2;

    assign run    = (state == ST_RUN);
    assign cnt_lo = cnt[ADDR_WIDTH-1:0];

    // A debug write may not share a cycle with a commit to the same entry:
    // the commit's order relative to the debug write would be ambiguous.
    assign dbg_hit = (com1_valid && (dbg_addr == com1_addr)) ||
                     (com2_valid && (dbg_addr == com2_addr));

    assign com_ready = run & ~clr_req;
    assign dbg_ready = run & ~clr_req & dbg_valid & ~(com1_valid & com2_valid) & ~dbg_hit;
    assign init_done = run;

    // Debug fills whichever port the commits leave free. dbg_ready already
    // excludes the both-commits case, so at most one of these is set and
    // port 2 is then guaranteed free of com2.
    assign dbg_acc = dbg_ready;
    assign dbg_p1  = dbg_acc & ~com1_valid;
    assign dbg_p2  = dbg_acc &  com1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_INIT;
            cnt    <= '0;
            we1    <= 1'b0;
            we2    <= 1'b0;
            waddr1 <= '0;
            waddr2 <= '0;
            wdata1 <= '0;
            wdata2 <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == LAST_CNT) begin
                        // The last pair was registered on the previous edge and
                        // lands in the RAM on this one, so RUN starts clean.
                        we1   <= 1'b0;
                        we2   <= 1'b0;
                        state <= ST_RUN;
                    end else begin
                        we1    <= 1'b1;
                        we2    <= 1'b1;
                        waddr1 <= cnt_lo;
                        // cnt is always even, so cnt+1 is cnt with bit 0 set.
                        waddr2 <= cnt_lo | ADDR_WIDTH'(1);
                        wdata1 <= INIT_VAL;
                        wdata2 <= INIT_VAL;
                        cnt    <= cnt + CNT_STEP;
                    end
                end

                ST_RUN: begin
                    if (clr_req) begin
                        // Nothing is accepted this cycle; the first clear pair
                        // is issued on the following edge.
                        state <= ST_INIT;
                        cnt   <= '0;
                        we1   <= 1'b0;
                        we2   <= 1'b0;
                    end else begin
                        we1 <= com1_valid | dbg_p1;
                        we2 <= com2_valid | dbg_p2;

                        if (com1_valid) begin
                            waddr1 <= com1_addr;
                            wdata1 <= com1_data;
                        end else if (dbg_p1) begin
                            waddr1 <= dbg_addr;
                            wdata1 <= dbg_data;
                        end

                        if (com2_valid) begin
                            waddr2 <= com2_addr;
                            wdata2 <= com2_data;
                        end else if (dbg_p2) begin
                            waddr2 <= dbg_addr;
                            wdata2 <= dbg_data;
                        end
                    end
                end

                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                    we1   <= 1'b0;
                    we2   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arf_write_scheduler.sv
// tb/tb_arf_write_scheduler.sv - scoreboard bench for arf_write_scheduler

module tb_arf_write_scheduler;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk;
    logic          reset;
    logic          clr_req;
    logic          init_done;
    logic          com1_valid, com2_valid;
    logic [AW-1:0] com1_addr, com2_addr;
    logic [DW-1:0] com1_data, com2_data;
    logic          com_ready;
    logic          dbg_valid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_ready;
    logic          we1, we2;
    logic [AW-1:0] waddr1, waddr2;
    logic [DW-1:0] wdata1, wdata2;

    arf_write_scheduler #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .INIT_VAL   ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .init_done  (init_done),
        .com1_valid (com1_valid),
        .com1_addr  (com1_addr),
        .com1_data  (com1_data),
        .com2_valid (com2_valid),
        .com2_addr  (com2_addr),
        .com2_data  (com2_data),
        .com_ready  (com_ready),
        .dbg_valid  (dbg_valid),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .we2        (we2),
        .waddr2     (waddr2),
        .wdata2     (wdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          we2;
        logic [AW-1:0] a2;
        logic [DW-1:0] d2;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;

    // RAM behind the write ports: port 2 is applied last so it wins.
    logic [DW-1:0] ram [DEPTH];
    logic          ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hDEAD0000 + DW'(i);
        end else begin
            if (we1) ram[waddr1] <= wdata1;
            if (we2) ram[waddr2] <= wdata2;
        end
    end

    // Reference model: RAM contents and what each edge should present.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_run;
    int            m_pair;
    logic [AW-1:0] m_a1, m_a2;
    logic [DW-1:0] m_d1, m_d2;
    bit            dbg_taken;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_pair = 0;
        m_a1   = '0;
        m_a2   = '0;
        m_d1   = '0;
        m_d2   = '0;
    endtask

    task automatic drive_idle();
        clr_req    = 1'b0;
        com1_valid = 1'b0;
        com2_valid = 1'b0;
        com1_addr  = '0;
        com2_addr  = '0;
        com1_data  = '0;
        com2_data  = '0;
    endtask

    // Called with inputs set just after an edge; checks the handshake,
    // predicts the next edge's outputs and queues that for the monitor.
    task automatic cycle();
        exp_t e;
        bit   hit, exp_cr, exp_dr;
        #1;
        hit    = (com1_valid && dbg_addr == com1_addr) || (com2_valid && dbg_addr == com2_addr);
        exp_cr = m_run && !clr_req;
        exp_dr = exp_cr && dbg_valid && !(com1_valid && com2_valid) && !hit;
        chk("handshake", {78'd0, com_ready, dbg_ready}, {78'd0, exp_cr, exp_dr});
        e.we1 = 1'b0;
        e.we2 = 1'b0;
        if (!m_run) begin
            if (m_pair < DEPTH / 2) begin
                e.we1 = 1'b1;
                e.we2 = 1'b1;
                m_a1  = AW'(2 * m_pair);
                m_a2  = AW'(2 * m_pair + 1);
                m_d1  = '0;
                m_d2  = '0;
                ref_mem[2 * m_pair]     = '0;
                ref_mem[2 * m_pair + 1] = '0;
                m_pair++;
            end else begin
                m_run = 1;
            end
        end else if (clr_req) begin
            m_run  = 0;
            m_pair = 0;
        end else begin
            if (com1_valid) begin
                e.we1 = 1'b1; m_a1 = com1_addr; m_d1 = com1_data;
                ref_mem[com1_addr] = com1_data;
            end
            if (com2_valid) begin
                e.we2 = 1'b1; m_a2 = com2_addr; m_d2 = com2_data;
                ref_mem[com2_addr] = com2_data;
            end
            if (exp_dr) begin
                if (!com1_valid) begin
                    e.we1 = 1'b1; m_a1 = dbg_addr; m_d1 = dbg_data;
                end else begin
                    e.we2 = 1'b1; m_a2 = dbg_addr; m_d2 = dbg_data;
                end
                ref_mem[dbg_addr] = dbg_data;
            end
        end
        e.a1   = m_a1;
        e.d1   = m_d1;
        e.a2   = m_a2;
        e.d2   = m_d2;
        e.done = m_run;
        dbg_taken = exp_dr;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic mem_check(input string name);
        int bad   = 0;
        int first = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ram[i] !== ref_mem[i]) begin
                bad++;
                first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d entries differ, entry %0d got %h expected %h",
                     name, bad, first, ram[first], ref_mem[first]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("edge_outputs", {3'd0, we1, waddr1, wdata1, we2, waddr2, wdata2, init_done},
                {3'd0, mon_e});
        end
    end

    initial begin
        reset     = 1'b1;
        ram_fill  = 1'b1;
        dbg_valid = 1'b0;
        dbg_addr  = '0;
        dbg_data  = '0;
        drive_idle();
        model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hDEAD0000 + DW'(i);
        #3;
        chk("reset_outputs", {3'd0, we1, waddr1, wdata1, we2, waddr2, wdata2, init_done, com_ready, dbg_ready}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        ram_fill = 1'b0;
        chk("reset_held", {3'd0, we1, waddr1, wdata1, we2, waddr2, wdata2, init_done, com_ready, dbg_ready}, '0);
        reset = 1'b0;

        // Initialisation from reset: 16 pair edges, then init_done on edge 17.
        idle(17);
        idle(2);
        mem_check("init_zero");

        // Two commits to distinct entries.
        com1_valid = 1; com1_addr = 3; com1_data = 32'hAAAA0001;
        com2_valid = 1; com2_addr = 7; com2_data = 32'hBBBB0002;
        cycle();
        idle(2);
        chk("entry3", {48'd0, ram[3]}, {48'd0, 32'hAAAA0001});
        chk("entry7", {48'd0, ram[7]}, {48'd0, 32'hBBBB0002});

        // Same-address collision: younger commit must be the final value.
        com1_valid = 1; com1_addr = 5; com1_data = 32'h11;
        com2_valid = 1; com2_addr = 5; com2_data = 32'h22;
        cycle();
        idle(2);
        chk("collision_entry5", {48'd0, ram[5]}, {48'd0, 32'h22});

        // Debug write held across blocking cycles.
        dbg_valid = 1; dbg_addr = 9; dbg_data = 32'hD0;
        com1_valid = 1; com1_addr = 1; com1_data = 32'h101;
        com2_valid = 1; com2_addr = 2; com2_data = 32'h102;
        cycle();
        com1_valid = 1; com1_addr = 9; com1_data = 32'h1;
        com2_valid = 0;
        cycle();
        com1_valid = 1; com1_addr = 4; com1_data = 32'h2;
        cycle();
        if (dbg_taken) dbg_valid = 0;
        idle(2);
        chk("debug_entry9", {48'd0, ram[9]}, {48'd0, 32'hD0});
        mem_check("after_debug");

        // Clear request: commits during the clear are refused.
        com1_valid = 1; com1_addr = 12; com1_data = 32'h55;
        cycle();
        idle(2);
        chk("entry12_set", {48'd0, ram[12]}, {48'd0, 32'h55});
        clr_req = 1; com1_valid = 1; com1_addr = 20; com1_data = 32'h77;
        cycle();
        clr_req = 0;
        for (int i = 0; i < 17; i++) begin
            com1_valid = 1; com1_addr = AW'($urandom_range(0, DEPTH - 1)); com1_data = $urandom;
            cycle();
        end
        idle(2);
        chk("entry12_cleared", {48'd0, ram[12]}, 80'd0);
        mem_check("after_clear");

        // Randomised traffic over a narrow address range to provoke
        // collisions and debug address matches; occasional clears.
        for (int n = 0; n < 400; n++) begin
            com1_valid = ($urandom_range(0, 3) != 0);
            com2_valid = ($urandom_range(0, 2) != 0);
            com1_addr  = AW'($urandom_range(0, 7));
            com2_addr  = AW'($urandom_range(0, 7));
            com1_data  = $urandom;
            com2_data  = $urandom;
            clr_req    = ($urandom_range(0, 99) == 0);
            if (!dbg_valid && $urandom_range(0, 2) == 0) begin
                dbg_valid = 1;
                dbg_addr  = AW'($urandom_range(0, 7));
                dbg_data  = $urandom;
            end
            cycle();
            if (dbg_taken) dbg_valid = 0;
        end
        drive_idle();
        for (int i = 0; i < 40 && (!m_run || dbg_valid); i++) begin
            cycle();
            if (dbg_taken) dbg_valid = 0;
        end
        idle(2);
        mem_check("after_random");

        // Reset asserted in the middle of a clear sequence.
        com1_valid = 1; com1_addr = 30; com1_data = 32'hCAFE;
        cycle();
        clr_req = 1; com1_valid = 0;
        cycle();
        clr_req = 0;
        idle(8);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_init", {3'd0, we1, waddr1, wdata1, we2, waddr2, wdata2, init_done, com_ready, dbg_ready}, '0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(17);
        idle(2);
        mem_check("after_reset_reinit");
        chk("final_init_done", {79'd0, init_done}, 80'd1);

        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
